// File: rtl/led_tx_pkg.sv
// Shared LED defines: default WS2812-style timing at 50 MHz, pixel width and the wire-order helper.
// Optional build macro LED_TX_GRB_EN selects {G,R,B} wire order instead of i_data as given.
package led_tx_pkg;

  localparam int LED_T0H     = 20;
  localparam int LED_T1H     = 40;
  localparam int LED_TBIT    = 63;
  localparam int LED_TRET    = 2600;
  localparam int LED_PIXEL_W = 24;
  localparam int LED_CNT_W   = 16;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_HIGH = 2'd1,
    ST_LOW  = 2'd2,
    ST_RET  = 2'd3
  } led_state_e;

  function automatic logic [LED_PIXEL_W-1:0] wire_order(input logic [LED_PIXEL_W-1:0] pixel);
`ifdef LED_TX_GRB_EN
    return {pixel[15:8], pixel[23:16], pixel[7:0]};
`else
    return pixel;
`endif
  endfunction

endpackage

// File: rtl/led_tx_if.sv
// Pixel handshake bundle between a pixel source (master) and led_tx (slave).
interface led_tx_if;
  import led_tx_pkg::*;

  logic [LED_PIXEL_W-1:0] i_data;
  logic                   i_last;
  logic                   i_valid;
  logic                   o_ready;

  modport master (output i_data, output i_last, output i_valid, input o_ready);
  modport slave  (input i_data, input i_last, input i_valid, output o_ready);

endinterface

// File: rtl/led_bit_timer.sv
// One-bit waveform timer: after a start pulse it spends T1H/T0H cycles high, then the rest of
// TBIT low, and strobes bit_done on the last cycle of the period.
module led_bit_timer
  import led_tx_pkg::*;
#(
  parameter int T0H  = LED_T0H,
  parameter int T1H  = LED_T1H,
  parameter int TBIT = LED_TBIT
) (
  input  logic clk,
  input  logic rst,
  input  logic start,
  input  logic bit_val,
  output logic high,
  output logic bit_done
);

  localparam logic [LED_CNT_W-1:0] HIGH0    = LED_CNT_W'(T0H);
  localparam logic [LED_CNT_W-1:0] HIGH1    = LED_CNT_W'(T1H);
  localparam logic [LED_CNT_W-1:0] LAST_CYC = LED_CNT_W'(TBIT - 1);

  logic [LED_CNT_W-1:0] cnt_r;
  logic                 active_r;
  logic                 bit_r;
  logic [LED_CNT_W-1:0] high_len_s;

  assign high_len_s = bit_r ? HIGH1 : HIGH0;
  assign high       = active_r && (cnt_r < high_len_s);
  assign bit_done   = active_r && (cnt_r == LAST_CYC);

  // Period counter; a start on the bit_done cycle chains the next bit with no gap.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_r    <= '0;
      active_r <= 1'b0;
      bit_r    <= 1'b0;
    end else if (start) begin
      cnt_r    <= '0;
      active_r <= 1'b1;
      bit_r    <= bit_val;
    end else if (bit_done) begin
      cnt_r    <= '0;
      active_r <= 1'b0;
      bit_r    <= bit_r;
    end else if (active_r) begin
      cnt_r    <= cnt_r + LED_CNT_W'(1);
      active_r <= 1'b1;
      bit_r    <= bit_r;
    end else begin
      cnt_r    <= cnt_r;
      active_r <= 1'b0;
      bit_r    <= bit_r;
    end
  end

endmodule

// File: rtl/led_tx.sv
// Single-wire addressable-LED transmitter: holding + shift register, IDLE/HIGH/LOW/RET sequencer.
// Build macro LED_TX_GRB_EN (see led_tx_pkg) reorders pixels to {G,R,B} on the wire.
module led_tx
  import led_tx_pkg::*;
#(
  parameter int T0H  = LED_T0H,
  parameter int T1H  = LED_T1H,
  parameter int TBIT = LED_TBIT,
  parameter int TRET = LED_TRET
) (
  input  logic    i_clk,
  input  logic    i_rst,
  led_tx_if.slave px,
  output logic    o_serial,
  output logic    o_busy,
  output logic    o_frame_done
);

  localparam logic [LED_CNT_W-1:0] RET_END  = LED_CNT_W'(TRET - 1);
  localparam logic [4:0]           LAST_BIT = 5'(LED_PIXEL_W - 1);

  if ((T0H >= T1H) || (T1H >= TBIT) || (TRET < TBIT)) begin : g_bad_timing
    $error("led_tx: timing must satisfy T0H < T1H < TBIT <= TRET");
  end

  led_state_e             state_r;
  logic [LED_PIXEL_W-1:0] hold_data_r;
  logic                   hold_last_r;
  logic                   hold_full_r;
  logic [LED_PIXEL_W-1:0] shift_r;
  logic                   shift_last_r;
  logic [4:0]             bit_cnt_r;
  logic [LED_CNT_W-1:0]   ret_cnt_r;
  logic                   ready_r;
  logic                   serial_r;
  logic                   frame_done_r;

  logic                   accept_s;
  logic                   load_s;
  logic                   start_s;
  logic                   start_bit_s;
  logic                   tmr_high_s;
  logic                   tmr_done_s;
  logic [LED_PIXEL_W-1:0] hold_wire_s;

  assign hold_wire_s  = wire_order(hold_data_r);
  assign accept_s     = px.i_valid && ready_r;
  assign px.o_ready   = ready_r;
  assign o_serial     = serial_r;
  assign o_frame_done = frame_done_r;
  assign o_busy       = (state_r != ST_IDLE) || hold_full_r;

  led_bit_timer #(
    .T0H  (T0H),
    .T1H  (T1H),
    .TBIT (TBIT)
  ) u_timer (
    .clk      (i_clk),
    .rst      (i_rst),
    .start    (start_s),
    .bit_val  (start_bit_s),
    .high     (tmr_high_s),
    .bit_done (tmr_done_s)
  );

  // Decide when the timer starts a bit and whether that bit comes from a freshly loaded pixel.
  always_comb begin
    load_s  = 1'b0;
    start_s = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (hold_full_r) begin
          load_s  = 1'b1;
          start_s = 1'b1;
        end else begin
          load_s  = 1'b0;
          start_s = 1'b0;
        end
      end
      ST_HIGH, ST_LOW: begin
        if (tmr_done_s && (bit_cnt_r != LAST_BIT)) begin
          load_s  = 1'b0;
          start_s = 1'b1;
        end else if (tmr_done_s && hold_full_r) begin
          load_s  = 1'b1;
          start_s = 1'b1;
        end else begin
          load_s  = 1'b0;
          start_s = 1'b0;
        end
      end
      ST_RET: begin
        if ((ret_cnt_r == RET_END) && hold_full_r) begin
          load_s  = 1'b1;
          start_s = 1'b1;
        end else begin
          load_s  = 1'b0;
          start_s = 1'b0;
        end
      end
      default: begin
        load_s  = 1'b0;
        start_s = 1'b0;
      end
    endcase
    start_bit_s = load_s ? hold_wire_s[LED_PIXEL_W-1] : shift_r[LED_PIXEL_W-2];
  end

  // Sequencer, storage and registered outputs. Serial follows the timer phase one cycle late.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_r      <= ST_IDLE;
      hold_data_r  <= '0;
      hold_last_r  <= 1'b0;
      hold_full_r  <= 1'b0;
      shift_r      <= '0;
      shift_last_r <= 1'b0;
      bit_cnt_r    <= 5'd0;
      ret_cnt_r    <= '0;
      ready_r      <= 1'b0;
      serial_r     <= 1'b0;
      frame_done_r <= 1'b0;
    end else begin
      serial_r     <= tmr_high_s;
      frame_done_r <= 1'b0;
      ready_r      <= !(accept_s || (hold_full_r && !load_s));

      if (accept_s) begin
        hold_data_r <= px.i_data;
        hold_last_r <= px.i_last;
        hold_full_r <= 1'b1;
      end else if (load_s) begin
        hold_full_r <= 1'b0;
      end

      if (load_s) begin
        shift_r      <= hold_wire_s;
        shift_last_r <= hold_last_r;
        bit_cnt_r    <= 5'd0;
      end else if (start_s) begin
        shift_r   <= {shift_r[LED_PIXEL_W-2:0], 1'b0};
        bit_cnt_r <= bit_cnt_r + 5'd1;
      end

      case (state_r)
        ST_IDLE: begin
          if (load_s) begin
            state_r <= ST_HIGH;
          end
        end
        ST_HIGH, ST_LOW: begin
          if (tmr_done_s) begin
            if (start_s) begin
              state_r <= ST_HIGH;
            end else if (shift_last_r) begin
              state_r   <= ST_RET;
              ret_cnt_r <= '0;
            end else begin
              state_r <= ST_IDLE;
            end
          end else begin
            state_r <= tmr_high_s ? ST_HIGH : ST_LOW;
          end
        end
        ST_RET: begin
          if (ret_cnt_r == RET_END) begin
            frame_done_r <= 1'b1;
            ret_cnt_r    <= '0;
            state_r      <= load_s ? ST_HIGH : ST_IDLE;
          end else begin
            ret_cnt_r <= ret_cnt_r + LED_CNT_W'(1);
          end
        end
        default: state_r <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_led_tx.sv
// Directed bench for led_tx: a negedge monitor decodes the serial line like an LED receiver.
module tb_led_tx;
  import led_tx_pkg::*;

  logic i_clk = 1'b0;
  logic i_rst = 1'b1;
  logic o_serial, o_busy, o_frame_done;

  led_tx_if px ();

  led_tx dut (
    .i_clk        (i_clk),
    .i_rst        (i_rst),
    .px           (px),
    .o_serial     (o_serial),
    .o_busy       (o_busy),
    .o_frame_done (o_frame_done)
  );

  always #5 i_clk = ~i_clk;

  int cyc = 0;
  always @(posedge i_clk) cyc <= cyc + 1;

  int checks = 0;
  int failures = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // Receiver model: only this block writes the monitor state; bumping mon_epoch clears it.
  int          mon_epoch = 0;
  int          seen_epoch = 0;
  logic        ser_prev = 1'b0;
  int          hi_len = 0, n_rise = 0, n_contig = 0, last_rise = 0;
  int          w20 = 0, w40 = 0, wbad = 0, rx_bits = 0, rx_n = 0;
  int          fd_count = 0, fd_cyc0 = 0;
  int          rises[64];
  logic [23:0] rx_sr = 24'h0;
  logic [23:0] rx_words[4];

  always @(negedge i_clk) begin
    if (seen_epoch != mon_epoch) begin
      hi_len = 0; n_rise = 0; n_contig = 0; last_rise = 0;
      w20 = 0; w40 = 0; wbad = 0; rx_bits = 0; rx_n = 0;
      fd_count = 0; fd_cyc0 = 0; rx_sr = 24'h0;
      for (int i = 0; i < 64; i++) rises[i] = 0;
      seen_epoch = mon_epoch;
    end
    if (o_serial === 1'b1) begin
      if (!ser_prev) begin
        if ((n_rise > 0) && (cyc - last_rise == LED_TBIT)) n_contig++;
        if (n_rise < 64) rises[n_rise] = cyc;
        last_rise = cyc;
        n_rise++;
      end
      hi_len++;
    end else if (ser_prev) begin
      rx_sr = {rx_sr[22:0], (hi_len > (LED_T0H + LED_T1H) / 2)};
      if (hi_len == LED_T0H) w20++;
      else if (hi_len == LED_T1H) w40++;
      else wbad++;
      rx_bits++;
      if (rx_bits == 24) begin
        if (rx_n < 4) rx_words[rx_n] = rx_sr;
        rx_n++;
        rx_bits = 0;
      end
      hi_len = 0;
    end
    if (o_frame_done === 1'b1) begin
      if (fd_count == 0) fd_cyc0 = cyc;
      fd_count++;
    end
    ser_prev = (o_serial === 1'b1);
  end

  function automatic logic [23:0] rx_word(input int i);
    return (rx_n > i) ? rx_words[i] : 24'hxxxxxx;
  endfunction

  int hs_cyc = 0;

  task automatic send(input logic [23:0] d, input logic l);
    logic ok;
    ok = 1'b0;
    @(negedge i_clk);
    px.i_data = d; px.i_last = l; px.i_valid = 1'b1;
    for (int k = 0; k < 6000; k++) begin
      @(posedge i_clk);
      if (px.o_ready === 1'b1) begin
        ok = 1'b1;
        hs_cyc = cyc;
        break;
      end
    end
    @(negedge i_clk);
    px.i_valid = 1'b0;
    check_eq("handshake", 32'(ok), 32'd1);
  endtask

  task automatic wait_fd(input int n, input int budget);
    for (int k = 0; k < budget; k++) begin
      @(posedge i_clk);
      if (fd_count >= n) break;
    end
    check_eq("frame_done_wait", 32'(fd_count >= n), 32'd1);
  endtask

  task automatic wait_rise(input int n, input int budget);
    for (int k = 0; k < budget; k++) begin
      @(posedge i_clk);
      if (n_rise >= n) break;
    end
    check_eq("rise_wait", 32'(n_rise >= n), 32'd1);
  endtask

  int          hs0;
  logic [23:0] grb_exp;

  initial begin
    px.i_data = 24'h0; px.i_last = 1'b0; px.i_valid = 1'b0;

    // Reset values, then ready on the first cycle after release.
    repeat (3) @(posedge i_clk);
    @(negedge i_clk);
    check_eq("rst_ready", 32'(px.o_ready), 32'd0);
    check_eq("rst_serial", 32'(o_serial), 32'd0);
    check_eq("rst_busy", 32'(o_busy), 32'd0);
    check_eq("rst_frame_done", 32'(o_frame_done), 32'd0);
    i_rst = 1'b0;
    @(negedge i_clk);
    check_eq("ready_after_rst", 32'(px.o_ready), 32'd1);

    // Single last pixel: handshake at edge E, serial high from E+2 (seen at the negedge after).
    mon_epoch++;
    send(24'hFF00FF, 1'b1);
    hs0 = hs_cyc;
    wait_fd(1, 6000);
    repeat (4) @(negedge i_clk);
    check_eq("s1_latency", 32'(rises[0] - hs0), 32'd3);
    check_eq("s1_word", 32'(rx_word(0)), 32'hFF00FF);
    check_eq("s1_frame_len", 32'(fd_cyc0 + 1 - rises[0]), 32'(24 * LED_TBIT + LED_TRET));
    check_eq("s1_fd_once", 32'(fd_count), 32'd1);
    check_eq("s1_bits", 32'(n_rise), 32'd24);
    check_eq("s1_busy", 32'(o_busy), 32'd0);

    // Two pixels back to back inside one frame: 48 contiguous periods.
    mon_epoch++;
    send(24'hA5C3F0, 1'b0);
    send(24'h3C5A96, 1'b1);
    wait_fd(1, 8000);
    repeat (2) @(negedge i_clk);
    check_eq("s2_bits", 32'(n_rise), 32'd48);
    check_eq("s2_contig", 32'(n_contig), 32'd47);
    check_eq("s2_word0", 32'(rx_word(0)), 32'hA5C3F0);
    check_eq("s2_word1", 32'(rx_word(1)), 32'h3C5A96);

    // Underrun: no follow-up pixel, back to IDLE with no frame_done.
    mon_epoch++;
    send(24'h123456, 1'b0);
    for (int k = 0; k < 3000; k++) begin
      @(posedge i_clk);
      if (o_busy === 1'b0) break;
    end
    check_eq("s3_busy_drop", 32'(o_busy), 32'd0);
    check_eq("s3_word", 32'(rx_word(0)), 32'h123456);
    repeat (LED_TRET + 100) @(posedge i_clk);
    @(negedge i_clk);
    check_eq("s3_bits", 32'(n_rise), 32'd24);
    check_eq("s3_no_fd", 32'(fd_count), 32'd0);
    check_eq("s3_serial_low", 32'(o_serial), 32'd0);
    check_eq("s3_busy", 32'(o_busy), 32'd0);

    // Reset during the high phase of bit 10, then a fresh pixel.
    mon_epoch++;
    send(24'hFFFFFF, 1'b1);
    wait_rise(11, 2000);
    @(negedge i_clk);
    check_eq("s4_high_before_rst", 32'(o_serial), 32'd1);
    i_rst = 1'b1;
    @(posedge i_clk);
    #1;
    check_eq("s4_serial_abort", 32'(o_serial), 32'd0);
    check_eq("s4_ready_rst", 32'(px.o_ready), 32'd0);
    repeat (2) @(negedge i_clk);
    check_eq("s4_ready_rst_hold", 32'(px.o_ready), 32'd0);
    check_eq("s4_busy_rst", 32'(o_busy), 32'd0);
    i_rst = 1'b0;
    mon_epoch++;
    send(24'h000001, 1'b1);
    wait_fd(1, 6000);
    repeat (2) @(negedge i_clk);
    check_eq("s4_word", 32'(rx_word(0)), 32'h000001);
    check_eq("s4_short_highs", 32'(w20), 32'd23);
    check_eq("s4_long_highs", 32'(w40), 32'd1);
    check_eq("s4_bad_highs", 32'(wbad), 32'd0);

    // Wire order.
`ifdef LED_TX_GRB_EN
    grb_exp = 24'h221133;
`else
    grb_exp = 24'h112233;
`endif
    mon_epoch++;
    send(24'h112233, 1'b1);
    wait_fd(1, 6000);
    repeat (2) @(negedge i_clk);
    check_eq("s5_order", 32'(rx_word(0)), 32'(grb_exp));

    // Two frames; the second pixel is offered during the first frame's RET.
    mon_epoch++;
    send(24'hC0FFEE, 1'b1);
    wait_rise(24, 2500);
    repeat (LED_TBIT + 10) @(posedge i_clk);
    send(24'h13579B, 1'b1);
    wait_fd(2, 8000);
    repeat (2) @(negedge i_clk);
    check_eq("s6_ret_gap", 32'(rises[24] - rises[23]), 32'(LED_TBIT + LED_TRET));
    check_eq("s6_start_after_fd", 32'(rises[24] - fd_cyc0), 32'd1);
    check_eq("s6_fd_count", 32'(fd_count), 32'd2);
    check_eq("s6_word0", 32'(rx_word(0)), 32'hC0FFEE);
    check_eq("s6_word1", 32'(rx_word(1)), 32'h13579B);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
